nvm_frame_receiver: RTL

Serial frame receiver placed directly downstream of the NVM reader. It consumes the reader's one-bit-per-clock DATA stream and recovers each byte. Each frame is idle-high, one start bit 0, 8 data bits LSB first, and one stop bit 1. Recovered bytes go to a single-entry holding register with a VALID/ACK handshake, along with a framing-error pulse, a sticky overrun flag and a good-frame counter for the consuming logic.

---
 rtl/nvm_frame_receiver_if.sv | 35 +++
 rtl/nvm_frame_receiver.sv | 103 ++++++++++
 2 files changed

// File: rtl/nvm_frame_receiver_if.sv
// Bundle between the NVM reader/consumer side and nvm_frame_receiver.
//   EN        : receive enable (reader Read); low aborts a frame in progress
//   DATA_IN   : serial line, one bit per clock, idle high
//   OUT_ACK   : consumer takes BYTE_OUT while OUT_VALID is high
//   BYTE_OUT  : last good byte
//   OUT_VALID : BYTE_OUT holds an unconsumed byte
//   FRAME_ERR : one-cycle pulse when a stop bit is sampled as 0
//   OVERRUN   : sticky, a good byte was dropped because the holding register was full
//   BUSY      : receiver is not idle
//   FRAME_CNT : good-frame count, wraps
// The slave modport is the receiver; the master modport is the reader/consumer side.
interface nvm_frame_receiver_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
);
  logic              EN;
  logic              DATA_IN;
  logic              OUT_ACK;
  logic [DATA_W-1:0] BYTE_OUT;
  logic              OUT_VALID;
  logic              FRAME_ERR;
  logic              OVERRUN;
  logic              BUSY;
  logic [CNT_W-1:0]  FRAME_CNT;

  modport master (
    output EN, DATA_IN, OUT_ACK,
    input  BYTE_OUT, OUT_VALID, FRAME_ERR, OVERRUN, BUSY, FRAME_CNT
  );

  modport slave (
    input  EN, DATA_IN, OUT_ACK,
    output BYTE_OUT, OUT_VALID, FRAME_ERR, OVERRUN, BUSY, FRAME_CNT
  );
endinterface

// File: rtl/nvm_frame_receiver.sv
// Serial frame receiver behind the NVM reader. Frames are idle-high: one start bit (0),
// DATA_W data bits LSB first, one stop bit (1). Good bytes go to a single-entry holding
// register with a VALID/ACK handshake.
// Ports:
//   CLK : clock, rising edge
//   RST : synchronous active-high reset
//   bus : nvm_frame_receiver_if slave modport (EN, DATA_IN, OUT_ACK in;
//         BYTE_OUT, OUT_VALID, FRAME_ERR, OVERRUN, BUSY, FRAME_CNT out)
module nvm_frame_receiver #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  nvm_frame_receiver_if.slave  bus
);

  localparam int unsigned BitCntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_W - 1);

  typedef enum logic [1:0] {StIdle, StData, StStop, StResync} state_e;

  state_e              state_q;
  logic [BitCntW-1:0]  bit_cnt_q;
  logic [DATA_W-1:0]   shift_q;
  logic [DATA_W-1:0]   byte_q;
  logic                valid_q;
  logic                frame_err_q;
  logic                overrun_q;
  logic [CNT_W-1:0]    frame_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      byte_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      frame_err_q <= 1'b0;
      // An ack consumes the held byte; a load later in this block overrides it.
      if (bus.OUT_ACK) valid_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (bus.EN && !bus.DATA_IN) begin
            state_q   <= StData;
            bit_cnt_q <= '0;
          end
        end

        StData: begin
          if (!bus.EN) begin
            state_q <= StIdle;
          end else begin
            shift_q <= {bus.DATA_IN, shift_q[DATA_W-1:1]};
            if (bit_cnt_q == LastBit) begin
              state_q <= StStop;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end

        StStop: begin
          if (!bus.EN) begin
            state_q <= StIdle;
          end else if (bus.DATA_IN) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
            if (!valid_q || bus.OUT_ACK) begin
              byte_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
            state_q <= StIdle;
          end else begin
            frame_err_q <= 1'b1;
            state_q     <= StResync;
          end
        end

        StResync: begin
          // Wait for the line to return high so a bad frame's tail is never taken as a start.
          if (!bus.EN || bus.DATA_IN) state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.BYTE_OUT  = byte_q;
  assign bus.OUT_VALID = valid_q;
  assign bus.FRAME_ERR = frame_err_q;
  assign bus.OVERRUN   = overrun_q;
  assign bus.FRAME_CNT = frame_cnt_q;
  assign bus.BUSY      = (state_q != StIdle);

endmodule
